// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_pkg : front-panel mode encodings and mem_loader FSM state codes    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_KEY = 3'd2,
        S_WR_REQ   = 3'd3,
        S_RD_REQ   = 3'd4,
        S_ADV      = 3'd5
    } ld_state_t;

    // Load and check are the only modes in which the loader owns the memory port.
    function automatic logic is_session(input logic [1:0] st);
        return (st == ST_LOAD) || (st == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_debounce : 2-flop synchroniser, stability filter, rising-edge pulse|
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module key_debounce #(
    parameter int DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], raw};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // Any sample agreeing with the current level restarts the stability window.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_loader : front-panel key/switch driven memory load and check engine|
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module mem_loader
    import cpu_pkg::*;
#(
    parameter int DB_CYCLES   = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpustate,
    input  logic        A1,
    input  logic [7:0]  D,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        read,
    output logic        write,
    output logic [7:0]  check_out,
    output logic        ptr_valid,
    output logic        busy,
    output logic        err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic          w_level;
    logic          w_press;
    logic          w_mode_chg;
    ld_state_t     r_state;
    logic [1:0]    r_mode;
    logic [7:0]    r_ptr;
    logic [7:0]    r_data;
    logic [7:0]    r_check;
    logic          r_read;
    logic          r_write;
    logic          r_ptr_valid;
    logic          r_busy;
    logic          r_err;
    logic [TW-1:0] r_tcnt;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (A1),
        .level (w_level),
        .press (w_press)
    );

    assign w_mode_chg = (cpustate != r_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= ST_IDLE;
            r_ptr       <= 8'h00;
            r_data      <= 8'h00;
            r_check     <= 8'h00;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_ptr_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_read      <= 1'b0;
                    r_write     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ptr_valid <= 1'b0;
                    r_err       <= 1'b0;
                    r_mode      <= cpustate;
                    if (is_session(cpustate)) begin
                        r_state <= S_ARM;
                    end
                end
                S_ARM, S_WAIT_KEY: begin
                    // Mode changes are only acted on outside a transaction.
                    if (w_mode_chg) begin
                        r_mode      <= cpustate;
                        r_ptr_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= is_session(cpustate) ? S_ARM : S_IDLE;
                    end else if (w_press) begin
                        if (r_state == S_ARM) begin
                            r_ptr       <= D;
                            r_ptr_valid <= 1'b1;
                            r_state     <= S_WAIT_KEY;
                        end else begin
                            r_busy <= 1'b1;
                            r_tcnt <= '0;
                            if (r_mode == ST_LOAD) begin
                                r_data  <= D;
                                r_write <= 1'b1;
                                r_state <= S_WR_REQ;
                            end else begin
                                r_read  <= 1'b1;
                                r_state <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_WR_REQ, S_RD_REQ: begin
                    if (mem_ack) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_busy  <= 1'b0;
                        if (r_state == S_RD_REQ) begin
                            r_check <= mem_rdata;
                        end
                        r_state <= S_ADV;
                    end else if (r_tcnt == TW'(ACK_TIMEOUT - 1)) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_WAIT_KEY;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_ADV: begin
                    r_ptr   <= r_ptr + 8'd1;
                    r_state <= S_WAIT_KEY;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr      = {8'h00, r_ptr};
    assign data      = r_data;
    assign read      = r_read;
    assign write     = r_write;
    assign check_out = r_check;
    assign ptr_valid = r_ptr_valid;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_loader : directed vector bench for mem_loader                  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_mem_loader;
    import cpu_pkg::*;

    localparam int DB = 20;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpustate;
    logic        A1;
    logic [7:0]  D;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        read;
    logic        write;
    logic [7:0]  check_out;
    logic        ptr_valid;
    logic        busy;
    logic        err;

    mem_loader #(.DB_CYCLES(DB), .ACK_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .A1(A1), .D(D),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .addr(addr), .data(data),
        .read(read), .write(write), .check_out(check_out),
        .ptr_valid(ptr_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // memory model
    logic       ack_tie = 1'b0, ack_man = 1'b0, ack_auto = 1'b1;
    int         ack_dly = 2;
    int         hold = 0;
    logic [7:0] mem [256];
    logic [15:0] log_addr [32];
    logic [7:0]  log_data [32];
    int         nlog = 0;
    int         wlen = 0, last_wlen = 0;
    int         cyc = 0, npress = 0, last_press_cyc = 0, rw_both = 0;

    assign mem_ack   = ack_tie | ack_man | (ack_auto & (read | write) & (hold == ack_dly));
    assign mem_rdata = mem[addr[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        hold <= ((read | write) && !mem_ack) ? hold + 1 : 0;
        if (write && mem_ack && !rst) begin
            mem[addr[7:0]]  <= data;
            log_addr[nlog]  <= addr;
            log_data[nlog]  <= data;
            nlog            <= nlog + 1;
        end
        if (write) wlen <= wlen + 1;
        else if (wlen != 0) begin
            last_wlen <= wlen;
            wlen      <= 0;
        end
    end

    always @(negedge clk) begin
        if (u_dut.w_press) begin
            npress         <= npress + 1;
            last_press_cyc <= cyc;
        end
        if (read && write) rw_both <= rw_both + 1;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] d);
        D  = d;
        A1 = 1'b1;
        tick(DB + 10);
        A1 = 1'b0;
        tick(DB + 10);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] d;
        logic [7:0] ptr;
        logic       vld;
        logic [7:0] chk;
        int         nwr;
    } vec_t;

    vec_t vt [6];

    initial begin
        int t0, np0, n0;
        logic got;
        vt[0] = '{ST_LOAD,  8'h10, 8'h10, 1'b1, 8'h00, 0};
        vt[1] = '{ST_LOAD,  8'hA5, 8'h11, 1'b1, 8'h00, 1};
        vt[2] = '{ST_LOAD,  8'h3C, 8'h12, 1'b1, 8'h00, 2};
        vt[3] = '{ST_CHECK, 8'h10, 8'h10, 1'b1, 8'h00, 2};
        vt[4] = '{ST_CHECK, 8'h77, 8'h11, 1'b1, 8'hA5, 2};
        vt[5] = '{ST_CHECK, 8'h00, 8'h12, 1'b1, 8'h3C, 2};

        rst = 1'b1; cpustate = ST_IDLE; A1 = 1'b0; D = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_addr", 32'(addr), 32'h0);
        chk("reset_outs", {25'd0, data == 8'h00, read, write, check_out == 8'h00, ptr_valid, busy, err},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        // load burst then check read-back
        for (int i = 0; i < 6; i++) begin
            cpustate = vt[i].mode;
            tick(3);
            press(vt[i].d);
            chk($sformatf("vec%0d_addr", i), 32'(addr), {16'h0, 8'h00, vt[i].ptr});
            chk($sformatf("vec%0d_vld", i), 32'(ptr_valid), 32'(vt[i].vld));
            chk($sformatf("vec%0d_chk", i), 32'(check_out), 32'(vt[i].chk));
            chk($sformatf("vec%0d_nwr", i), nlog, vt[i].nwr);
        end
        chk("burst_w0", {log_addr[0], log_data[0]}, {16'h0010, 8'hA5});
        chk("burst_w1", {log_addr[1], log_data[1]}, {16'h0011, 8'h3C});

        // wrap with zero-latency ack
        cpustate = ST_IDLE; tick(3);
        ack_tie = 1'b1; cpustate = ST_LOAD; tick(3);
        press(8'hFF);
        chk("wrap_start", 32'(addr), 32'h00FF);
        press(8'h11);
        chk("wrap_w0", {log_addr[2], log_data[2]}, {16'h00FF, 8'h11});
        chk("wrap_len0", last_wlen, 1);
        press(8'h22);
        chk("wrap_w1", {log_addr[3], log_data[3]}, {16'h0000, 8'h22});
        chk("wrap_len1", last_wlen, 1);
        chk("wrap_ptr", 32'(addr), 32'h0001);
        ack_tie = 1'b0;

        // bounce filter
        cpustate = ST_IDLE; tick(3);
        np0 = npress;
        for (int i = 0; i < 12; i++) begin
            A1 = ~A1;
            tick(5);
        end
        t0 = cyc;
        A1 = 1'b1;
        tick(DB + 10);
        chk("bounce_count", npress - np0, 1);
        chk("bounce_latency", last_press_cyc - t0, DB + 3);
        A1 = 1'b0;
        tick(DB + 10);

        // timeout and retry
        ack_auto = 1'b0; cpustate = ST_LOAD; tick(3);
        press(8'h40);
        n0 = nlog;
        press(8'h55);
        chk("to_len", last_wlen, TO);
        chk("to_err", 32'(err), 32'h1);
        chk("to_ptr", 32'(addr), 32'h0040);
        chk("to_nolog", nlog, n0);
        ack_auto = 1'b1;
        press(8'h66);
        chk("retry_w", {log_addr[n0], log_data[n0]}, {16'h0040, 8'h66});
        chk("retry_ptr", 32'(addr), 32'h0041);
        chk("err_sticky", 32'(err), 32'h1);

        // mode change while a write is held
        ack_auto = 1'b0;
        n0 = nlog;
        D = 8'h77; A1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick(1);
            got = write;
        end
        chk("mc_write_seen", 32'(got), 32'h1);
        tick(1);
        cpustate = ST_RUN;
        tick(3);
        chk("mc_held", 32'(write), 32'h1);
        ack_man = 1'b1;
        tick(1);
        ack_man = 1'b0;
        chk("mc_w", {log_addr[n0], log_data[n0]}, {16'h0041, 8'h77});
        tick(5);
        chk("mc_idle", {28'd0, read, write, busy, err}, 32'h0);
        chk("mc_vld", 32'(ptr_valid), 32'h0);
        chk("mc_state", 32'(u_dut.r_state), 32'(S_IDLE));
        A1 = 1'b0;
        tick(DB + 10);
        chk("rw_exclusive", rw_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
